// File: rtl/fetch_pkg.sv
// ============================================================================
// Module   : fetch_pkg
// Purpose  : Shared constants and the prefetch entry type for the RV32 fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        misalign;
    } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
// Module   : fetch_fifo
// Purpose  : Ordered prefetch FIFO; a clear may load one entry in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    output logic [$clog2(DEPTH):0]   count,
    output fetch_entry_t             head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t     r_mem [DEPTH];
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;

    logic             w_do_pop;
    logic             w_do_push;
    logic             w_wr_en;
    logic [PW-1:0]    w_wr_idx;

    assign w_do_pop  = pop && (r_count != '0);
    assign w_do_push = push && ((r_count != CW'(DEPTH)) || w_do_pop);
    // A clear with push restarts the FIFO holding just the new entry in slot 0.
    assign w_wr_en   = !reset && push && (clear || w_do_push);
    assign w_wr_idx  = clear ? '0 : r_wr_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (clear) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= push ? PW'(1) : '0;
            r_count  <= push ? CW'(1) : '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[w_wr_idx] <= push_data;
    end

    assign count = r_count;
    assign head  = r_mem[r_rd_ptr];

endmodule

`default_nettype wire

// File: rtl/fetch_unit_rv32.sv
// ============================================================================
// Module   : fetch_unit_rv32
// Purpose  : RV32 fetch stage: PC, 1-cycle IMEM issue, prefetch FIFO, redirects.
//            Optional macro FETCH_MISALIGN_TRAP_EN enables misaligned-target trap.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit_rv32
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 2,
    parameter int          IMEM_AW    = 10
) (
    input  logic               clockCPU,
    input  logic               reset,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic               imem_req,
    input  logic [31:0]        imem_rdata,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    input  logic               id_ready,
    output logic               id_valid,
    output logic [31:0]        id_pc,
    output logic [31:0]        id_instr,
    output logic               id_misalign,
    output logic [31:0]        pc_out
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]   r_pc;
    logic [31:0]   r_inflight_pc;
    logic          r_inflight;
    logic          r_kill;
    logic          r_halt;

    logic [CW-1:0] w_count;
    fetch_entry_t  w_head;
    fetch_entry_t  w_push_data;
    logic          w_push;
    logic          w_pop;
    logic          w_live_resp;
    logic          w_misalign_tgt;
    logic [CW:0]   w_occ;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign w_misalign_tgt = redirect_pc[1];
    assign id_misalign    = id_valid & w_head.misalign;
`else
    logic unused_head_misalign;
    assign w_misalign_tgt       = 1'b0;
    assign id_misalign          = 1'b0;
    assign unused_head_misalign = w_head.misalign;
`endif

    assign w_pop       = id_valid & id_ready;
    assign w_live_resp = r_inflight & ~r_kill;
    // Occupancy after this cycle if nothing new is issued; keeps the FIFO from overflowing.
    assign w_occ       = {1'b0, w_count} + (CW+1)'(w_live_resp) - (CW+1)'(w_pop);
    assign imem_req    = !reset && !r_halt && (w_occ < (CW+1)'(FIFO_DEPTH));
    assign imem_addr   = r_pc[IMEM_AW+1:2];

    assign w_push      = redirect_valid ? w_misalign_tgt : w_live_resp;
    assign w_push_data = redirect_valid ? '{pc: redirect_pc, instr: NOP_INSTR, misalign: 1'b1}
                                        : '{pc: r_inflight_pc, instr: imem_rdata, misalign: 1'b0};

    fetch_fifo #(
        .DEPTH     (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clockCPU),
        .reset     (reset),
        .clear     (redirect_valid),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_pop),
        .count     (w_count),
        .head      (w_head)
    );

    always_ff @(posedge clockCPU) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_inflight_pc <= '0;
            r_inflight    <= 1'b0;
            r_kill        <= 1'b0;
            r_halt        <= 1'b0;
        end else begin
            r_inflight    <= imem_req;
            r_inflight_pc <= r_pc;
            // A request issued alongside a redirect returns stale data next cycle.
            r_kill        <= redirect_valid & imem_req;
            if (redirect_valid) begin
                r_pc   <= {redirect_pc[31:2], 2'b00};
                r_halt <= w_misalign_tgt;
            end else if (imem_req) begin
                r_pc   <= r_pc + 32'd4;
            end
        end
    end

    assign id_valid = (w_count != '0);
    assign id_pc    = id_valid ? w_head.pc    : 32'h0;
    assign id_instr = id_valid ? w_head.instr : NOP_INSTR;
    assign pc_out   = r_pc;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit_rv32.sv
// ============================================================================
// Module   : tb_fetch_unit_rv32
// Purpose  : Directed vector bench for fetch_unit_rv32 (RAM returns tagged address).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit_rv32;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  imem_addr;
    logic        imem_req;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        id_ready = 1'b1;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic        id_misalign;
    logic [31:0] pc_out;

    int n_cmp = 0;
    int n_bad = 0;

    fetch_unit_rv32 #(
        .RESET_PC   (32'h0040_0000),
        .FIFO_DEPTH (2),
        .IMEM_AW    (10)
    ) dut (
        .clockCPU       (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_req       (imem_req),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_instr       (id_instr),
        .id_misalign    (id_misalign),
        .pc_out         (pc_out)
    );

    always #5 clk = ~clk;

    // Synchronous RAM model: word tagged with its byte address.
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= 32'hA000_0000 | {20'h0, imem_addr, 2'b00};
    end

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return 32'hA000_0000 | (pc & 32'h0000_0FFC);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic rdy, input logic rv, input logic [31:0] rp);
        @(negedge clk);
        reset          = r;
        id_ready       = rdy;
        redirect_valid = rv;
        redirect_pc    = rp;
        #1;
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
    endtask

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        exp_req;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_pcout;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(input logic rst, input logic rdy, input logic req,
                                input logic vld, input logic [31:0] pc, input logic [31:0] pco);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.exp_req = req; v.exp_valid = vld;
        v.exp_pc = pc; v.exp_pcout = pco;
        return v;
    endfunction

    initial begin
        // Reset, streaming start-up, 6-cycle stall and release.
        vecs[0]  = mk(1, 1, 0, 0, 32'h0,         32'h0040_0000);
        vecs[1]  = mk(1, 1, 0, 0, 32'h0,         32'h0040_0000);
        vecs[2]  = mk(0, 1, 1, 0, 32'h0,         32'h0040_0000);
        vecs[3]  = mk(0, 1, 1, 0, 32'h0,         32'h0040_0004);
        vecs[4]  = mk(0, 1, 1, 1, 32'h0040_0000, 32'h0040_0008);
        vecs[5]  = mk(0, 1, 1, 1, 32'h0040_0004, 32'h0040_000C);
        vecs[6]  = mk(0, 1, 1, 1, 32'h0040_0008, 32'h0040_0010);
        for (int k = 7; k <= 12; k++)
            vecs[k] = mk(0, 0, 0, 1, 32'h0040_000C, 32'h0040_0014);
        vecs[13] = mk(0, 1, 1, 1, 32'h0040_000C, 32'h0040_0014);
        vecs[14] = mk(0, 1, 1, 1, 32'h0040_0010, 32'h0040_0018);
        vecs[15] = mk(0, 1, 1, 1, 32'h0040_0014, 32'h0040_001C);
        vecs[16] = mk(0, 1, 1, 1, 32'h0040_0018, 32'h0040_0020);

        for (int i = 0; i < 17; i++) begin
            step(vecs[i].rst, vecs[i].rdy, 1'b0, 32'h0);
            chk($sformatf("v%0d.req", i),   32'(imem_req),    32'(vecs[i].exp_req));
            chk($sformatf("v%0d.valid", i), 32'(id_valid),    32'(vecs[i].exp_valid));
            chk($sformatf("v%0d.pc", i),    id_pc,            vecs[i].exp_pc);
            chk($sformatf("v%0d.instr", i), id_instr,
                vecs[i].exp_valid ? instr_of(vecs[i].exp_pc) : 32'h0000_0013);
            chk($sformatf("v%0d.pcout", i), pc_out,           vecs[i].exp_pcout);
            chk($sformatf("v%0d.mis", i),   32'(id_misalign), 32'h0);
            if (vecs[i].exp_req)
                chk($sformatf("v%0d.addr", i), 32'(imem_addr), 32'(vecs[i].exp_pcout[11:2]));
        end

        // Redirect while FIFO full and a request is being issued.
        do_reset();
        for (int k = 0; k < 4; k++) step(0, 0, 0, 32'h0);
        chk("A.full_pc", id_pc, 32'h0040_0000);
        step(0, 1, 1, 32'h0040_0100);
        chk("A.req_at_redirect", 32'(imem_req), 32'h1);
        step(0, 1, 0, 32'h0);
        chk("A.c1.valid", 32'(id_valid), 32'h0);
        chk("A.c1.req", 32'(imem_req), 32'h1);
        chk("A.c1.addr", 32'(imem_addr), 32'h40);
        step(0, 1, 0, 32'h0);
        chk("A.c2.valid", 32'(id_valid), 32'h0);
        step(0, 1, 0, 32'h0);
        chk("A.c3.valid", 32'(id_valid), 32'h1);
        chk("A.c3.pc", id_pc, 32'h0040_0100);
        chk("A.c3.instr", id_instr, instr_of(32'h0040_0100));
        step(0, 1, 0, 32'h0);
        chk("A.c4.pc", id_pc, 32'h0040_0104);

        // Redirect coinciding with pop of 0x0040_0008.
        do_reset();
        for (int k = 0; k < 4; k++) step(0, 1, 0, 32'h0);
        step(0, 1, 1, 32'h0040_0200);
        chk("B.popped_pc", id_pc, 32'h0040_0008);
        step(0, 1, 0, 32'h0);
        chk("B.c1.valid", 32'(id_valid), 32'h0);
        step(0, 1, 0, 32'h0);
        chk("B.c2.valid", 32'(id_valid), 32'h0);
        step(0, 1, 0, 32'h0);
        chk("B.c3.valid", 32'(id_valid), 32'h1);
        chk("B.c3.pc", id_pc, 32'h0040_0200);

        // Reset with FIFO occupied and a response in flight.
        do_reset();
        for (int k = 0; k < 3; k++) step(0, 0, 0, 32'h0);
        step(0, 1, 0, 32'h0);
        chk("C.issue_pcout", pc_out, 32'h0040_0008);
        step(1, 0, 0, 32'h0);
        chk("C.rst.req", 32'(imem_req), 32'h0);
        step(0, 0, 0, 32'h0);
        chk("C.c1.valid", 32'(id_valid), 32'h0);
        chk("C.c1.pcout", pc_out, 32'h0040_0000);
        step(0, 0, 0, 32'h0);
        chk("C.c2.valid", 32'(id_valid), 32'h0);
        step(0, 0, 0, 32'h0);
        chk("C.c3.valid", 32'(id_valid), 32'h1);
        chk("C.c3.pc", id_pc, 32'h0040_0000);

        // Misaligned redirect target.
        do_reset();
        for (int k = 0; k < 4; k++) step(0, 1, 0, 32'h0);
        step(0, 1, 1, 32'h0040_0102);
`ifdef FETCH_MISALIGN_TRAP_EN
        step(0, 0, 0, 32'h0);
        chk("D.valid", 32'(id_valid), 32'h1);
        chk("D.pc", id_pc, 32'h0040_0102);
        chk("D.instr", id_instr, 32'h0000_0013);
        chk("D.mis", 32'(id_misalign), 32'h1);
        chk("D.req0", 32'(imem_req), 32'h0);
        step(0, 0, 0, 32'h0);
        chk("D.req1", 32'(imem_req), 32'h0);
        step(0, 1, 0, 32'h0);
        chk("D.pop.mis", 32'(id_misalign), 32'h1);
        step(0, 1, 0, 32'h0);
        chk("D.after.valid", 32'(id_valid), 32'h0);
        chk("D.after.mis", 32'(id_misalign), 32'h0);
        chk("D.after.req", 32'(imem_req), 32'h0);
        step(0, 1, 1, 32'h0040_0100);
        chk("D.redir.req", 32'(imem_req), 32'h0);
        step(0, 1, 0, 32'h0);
        chk("D.resume.req", 32'(imem_req), 32'h1);
        chk("D.resume.addr", 32'(imem_addr), 32'h40);
`else
        step(0, 1, 0, 32'h0);
        chk("D.c1.valid", 32'(id_valid), 32'h0);
        chk("D.c1.req", 32'(imem_req), 32'h1);
        chk("D.c1.pcout", pc_out, 32'h0040_0100);
        step(0, 1, 0, 32'h0);
        step(0, 1, 0, 32'h0);
        chk("D.c3.valid", 32'(id_valid), 32'h1);
        chk("D.c3.pc", id_pc, 32'h0040_0100);
        chk("D.c3.mis", 32'(id_misalign), 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
